// File: rtl/hilo_divider.sv
// hilo_divider
//   Multi-cycle MIPS DIV/DIVU execution unit that sits beside the ALU in the
//   execute stage. The quotient goes to LO and the remainder goes to HI. The
//   pipeline issues a request and then stalls while busy is high.
//
//   Signed division uses C/MIPS truncation, so the remainder takes the sign of
//   the dividend. Both results are held until the next completion.
//
// Ports
//   clk        rising-edge system clock
//   rst        asynchronous, active-high reset
//   start      request strobe; only accepted while busy == 0
//   is_signed  1 = DIV (two's complement), 0 = DIVU; sampled with start
//   dividend   numerator (rs); sampled with start
//   divisor    denominator (rt); sampled with start
//   busy       high while a request is in progress
//   done       one-cycle pulse; hi/lo were updated on the edge before it
//   div_zero   qualifies done: the divisor was zero
//   hi         remainder register
//   lo         quotient register
module hilo_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIXUP,
    S_ZERO
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_diff;
  logic             fits;

  // This returns the magnitude of x when it is treated as signed. The most
  // negative value maps to 2^(WIDTH-1), which is read as an unsigned number.
  function automatic logic [WIDTH-1:0] magnitude(input logic sgn,
                                                 input logic [WIDTH-1:0] x);
    return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  assign busy = (state != S_IDLE);

  // One restoring step. Bring in the next dividend bit from the top of quo,
  // then compare at WIDTH+1 bits. The remainder before the shift is always
  // less than the divisor, so when the subtraction happens its result fits
  // in WIDTH bits.
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign fits      = (rem_shift >= {1'b0, dvsr});
  assign rem_diff  = rem_shift[WIDTH-1:0] - dvsr;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic. A start only counts while the unit is in IDLE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (divisor == '0) ? S_ZERO : S_ITER;
        end
      end
      S_ITER:  if (count == LAST_STEP) state_next = S_FIXUP;
      S_FIXUP: state_next = S_IDLE;
      S_ZERO:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and result registers. quo starts out holding the dividend
  // magnitude. Quotient bits shift in at the bottom while dividend bits
  // shift out at the top. On a divide-by-zero, quo keeps the raw dividend
  // instead, because that value is what HI must return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            quo   <= (divisor == '0) ? dividend : magnitude(is_signed, dividend);
            dvsr  <= magnitude(is_signed, divisor);
            rem   <= '0;
            count <= '0;
            neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= is_signed & dividend[WIDTH-1];
          end
        end
        S_ITER: begin
          rem   <= fits ? rem_diff : rem_shift[WIDTH-1:0];
          quo   <= {quo[WIDTH-2:0], fits};
          count <= count + CW'(1);
        end
        S_FIXUP: begin
          lo   <= neg_q ? (~quo + 1'b1) : quo;
          hi   <= neg_r ? (~rem + 1'b1) : rem;
          done <= 1'b1;
        end
        S_ZERO: begin
          hi       <= quo;
          lo       <= '1;
          done     <= 1'b1;
          div_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_divider.sv
// tb_hilo_divider
//   Exercises hilo_divider at WIDTH = 32. The stimulus is a mix of directed
//   corner cases and random operations. Each result is compared with a plain
//   arithmetic reference model.
module tb_hilo_divider;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checkCount = 0;
  int passCount  = 0;

  hilo_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .is_signed(is_signed),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .div_zero(div_zero),
    .hi(hi),
    .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison goes through this task.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model built from ordinary integer division on 64-bit values.
  // SystemVerilog division truncates toward zero, so the remainder takes the
  // sign of the dividend. MIN / -1 comes out as 2^31, which truncates to MIN
  // with a remainder of 0.
  function automatic void refModel(input logic sgn, input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   output logic [W-1:0] q,
                                   output logic [W-1:0] r);
    longint sa, sb;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one request and wait, within a bound, for done. The operand inputs
  // are scrambled after the start edge. If intrudeAt is nonzero, a stray
  // start is pulsed after that many edges.
  task automatic applyStimulus(input logic sgn, input logic [W-1:0] a,
                               input logic [W-1:0] b, input int intrudeAt,
                               input string tag);
    logic [W-1:0] expQ, expR;
    int lat;
    refModel(sgn, a, b, expQ, expR);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = -1;
    for (int k = 1; k <= 100; k++) begin
      dividend  = $urandom;
      divisor   = $urandom;
      is_signed = 1'($urandom);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (k == 1 && b != 0) begin
        checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
        checkOutput({tag, "_dz_idle"}, 64'(div_zero), 64'd0);
      end
      if (done) begin
        lat = k;
        break;
      end
      if (k == intrudeAt) start = 1'b1;
    end
    checkOutput({tag, "_latency"}, 64'(lat), (b == 0) ? 64'd1 : 64'(W + 1));
    checkOutput({tag, "_lo"}, 64'(lo), 64'(expQ));
    checkOutput({tag, "_hi"}, 64'(hi), 64'(expR));
    checkOutput({tag, "_div_zero"}, 64'(div_zero), 64'(b == 0));
    checkOutput({tag, "_busy_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    int           sawDone;

    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_div_zero", 64'(div_zero), 64'd0);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases.
    applyStimulus(1'b1, 32'd100, 32'hFFFF_FFFD, 0, "div_100_m3");
    applyStimulus(1'b0, 32'd100, 32'hFFFF_FFFD, 0, "divu_100_big");
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min_m1");
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 0, "divu_max_1");
    applyStimulus(1'b1, 32'd5, 32'd0, 0, "div_5_0");
    applyStimulus(1'b1, 32'd1000, 32'd9, 10, "intrude");
    // This request starts in the same cycle that the previous done is high.
    applyStimulus(1'b1, 32'hFFFF_FC18, 32'd7, 0, "back_to_back");

    // Reset arrives partway through the iteration phase.
    applyStimulus(1'b1, 32'd100, 32'hFFFF_FFFD, 0, "pre_reset");
    is_signed = 1'b0;
    dividend  = 32'd12345;
    divisor   = 32'd17;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_done", 64'(done), 64'd0);
    checkOutput("midrst_hi", 64'(hi), 64'd0);
    checkOutput("midrst_lo", 64'(lo), 64'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    sawDone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) sawDone++;
    end
    checkOutput("midrst_no_done", 64'(sawDone), 64'd0);
    applyStimulus(1'b1, 32'd100, 32'd7, 0, "div_100_7");

    // Random operations, with the special divisors mixed in.
    for (int n = 0; n < 30; n++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = 32'($urandom_range(1, 20));
        3:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      applyStimulus(rs, ra, rb, (n % 3 == 0) ? 5 : 0, "random");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
